// File: rtl/lane_swap_pipe_if.sv
// rtl/lane_swap_pipe_if.sv - stream handshake bundle for lane_swap_pipe
// Upstream word plus transform select, and the downstream transformed word.
interface lane_swap_pipe_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 4
);
    localparam int NL   = DATA_W / LANE_W;
    localparam int RA_W = $clog2(NL);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        mode;
    logic [RA_W-1:0]   rot_amt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, mode, rot_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, rot_amt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lane_swap_pipe.sv
// rtl/lane_swap_pipe.sv - lane permutation stage with output register and skid buffer
// Words are transformed on acceptance; only transformed data is held in OR/SK.
module lane_swap_pipe #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    lane_swap_pipe_if.slave  bus,
    output logic [CNT_W-1:0] xfer_cnt
);
    localparam int NL = DATA_W / LANE_W;

    logic [DATA_W-1:0] xf_data;
    logic [DATA_W-1:0] or_data;
    logic              or_valid;
    logic [DATA_W-1:0] sk_data;
    logic              sk_valid;
    logic              accept;
    logic              out_fire;

    always_comb begin
        xf_data = bus.in_data;
        case (bus.mode)
            2'b01: begin
                for (int k = 0; k < NL; k += 2) begin
                    xf_data[k*LANE_W +: LANE_W]     = bus.in_data[(k+1)*LANE_W +: LANE_W];
                    xf_data[(k+1)*LANE_W +: LANE_W] = bus.in_data[k*LANE_W +: LANE_W];
                end
            end
            2'b10: begin
                for (int i = 0; i < NL; i++) begin
                    xf_data[(NL-1-i)*LANE_W +: LANE_W] = bus.in_data[i*LANE_W +: LANE_W];
                end
            end
            2'b11: begin
                // Left rotate: lane i lands at lane (i + rot_amt) mod NL.
                for (int i = 0; i < NL; i++) begin
                    xf_data[((i + int'(bus.rot_amt)) % NL)*LANE_W +: LANE_W] =
                        bus.in_data[i*LANE_W +: LANE_W];
                end
            end
            default: ;
        endcase
    end

    assign accept        = bus.in_valid && !sk_valid;
    assign out_fire      = or_valid && bus.out_ready;
    assign bus.in_ready  = !sk_valid;
    assign bus.out_valid = or_valid;
    assign bus.out_data  = or_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            or_valid <= 1'b0;
            or_data  <= '0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
            xfer_cnt <= '0;
        end else begin
            if (out_fire) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (sk_valid) begin
                // OR is necessarily full here; refill it from the skid slot.
                if (bus.out_ready) begin
                    or_data  <= sk_data;
                    sk_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!or_valid || bus.out_ready) begin
                    or_data  <= xf_data;
                    or_valid <= 1'b1;
                end else begin
                    sk_data  <= xf_data;
                    sk_valid <= 1'b1;
                end
            end else if (bus.out_ready) begin
                or_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lane_swap_pipe.sv
// tb/tb_lane_swap_pipe.sv - self-checking bench for lane_swap_pipe
// A second instance with a 4-bit counter shares all stimulus to exercise wrap.
module tb_lane_swap_pipe;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] xfer_cnt;
    logic [3:0]  cnt4;

    lane_swap_pipe_if #(.DATA_W(32), .LANE_W(4)) bus ();
    lane_swap_pipe_if #(.DATA_W(32), .LANE_W(4)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.mode      = bus.mode;
    assign bus4.rot_amt   = bus.rot_amt;
    assign bus4.out_ready = bus.out_ready;

    lane_swap_pipe #(.DATA_W(32), .LANE_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .xfer_cnt(xfer_cnt)
    );

    lane_swap_pipe #(.DATA_W(32), .LANE_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .xfer_cnt(cnt4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int fires = 0;
    logic [31:0] q[$];

    function automatic logic [31:0] model(logic [31:0] d, logic [1:0] m, int r);
        logic [31:0] lanes [8];
        logic [31:0] res;
        logic [63:0] dd;
        for (int i = 0; i < 8; i++) lanes[i] = (d >> (4 * i)) & 32'hF;
        res = 32'h0;
        case (m)
            2'b00: res = d;
            2'b01: for (int i = 0; i < 8; i++) res = res | (lanes[i ^ 1] << (4 * i));
            2'b10: for (int i = 0; i < 8; i++) res = res | (lanes[7 - i] << (4 * i));
            default: begin
                dd  = {d, d} << (4 * r);
                res = dd[63:32];
            end
        endcase
        return res;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (bus.out_valid && bus.out_ready) begin
            fires++;
            exp_cnt++;
            check("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) check("sb_data", 64'(bus.out_data), 64'(q.pop_front()));
        end
        if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.in_data, bus.mode, int'(bus.rot_amt)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_cnt = 0;
        #1;
    endtask

    task automatic push(logic [31:0] d, logic [1:0] m, logic [2:0] r);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        bus.rot_amt  = r;
        tick();
    endtask

    initial begin
        logic [31:0] tr_exp [4];
        int n;
        tr_exp[0] = 32'h12345678;
        tr_exp[1] = 32'h21436587;
        tr_exp[2] = 32'h87654321;
        tr_exp[3] = 32'h23456781;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'b00;
        bus.rot_amt   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        do_reset();
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // transform table, one cycle after acceptance
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            push(32'h12345678, 2'(m), 3'd1);
            bus.in_valid = 1'b0;
            check($sformatf("xf_valid_m%0d", m), 64'(bus.out_valid), 64'd1);
            check($sformatf("xf_data_m%0d", m), 64'(bus.out_data), 64'(tr_exp[m]));
            tick();
        end
        push(32'h12345678, 2'b11, 3'd0);
        bus.in_valid = 1'b0;
        check("rot0_pass", 64'(bus.out_data), 64'h12345678);
        tick();

        // backpressure: second word lands in the skid slot
        bus.out_ready = 1'b0;
        push(32'hA, 2'b00, 3'd0);
        push(32'hB, 2'b00, 3'd0);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        push(32'hC, 2'b01, 3'd5);
        push(32'hC, 2'b01, 3'd5);
        bus.in_valid = 1'b0;
        check("bp_hold_a", 64'(bus.out_data), 64'hA);
        check("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        check("bp_then_b", 64'(bus.out_data), 64'hB);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // random stalls against the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (i % 3 == 0));
            bus.in_data   = $urandom;
            bus.mode      = 2'($urandom_range(0, 3));
            bus.rot_amt   = 3'($urandom_range(0, 7));
            tick();
            if (q.size() > 2) check("occupancy_le2", 64'(q.size()), 64'd2);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("rand_drained", 64'(bus.out_valid), 64'd0);
        check("rand_sb_empty", 64'(q.size()), 64'd0);
        check("rand_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt[15:0]));

        // asynchronous reset with both slots full
        bus.out_ready = 1'b0;
        push(32'h11111111, 2'b00, 3'd0);
        push(32'h22222222, 2'b00, 3'd0);
        bus.in_valid = 1'b0;
        check("mid_full", 64'(bus.in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_xfer_cnt", 64'(xfer_cnt), 64'd0);
        check("mid_out_data", 64'(bus.out_data), 64'd0);
        #1;
        reset = 1'b0;
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        check("mid_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        push(32'hCAFE0123, 2'b10, 3'd0);
        bus.in_valid = 1'b0;
        check("mid_next_word", 64'(bus.out_data), 64'h3210EFAC);
        tick();

        // streaming at full rate
        do_reset();
        bus.out_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 100; i++) begin
            push($urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            if (bus.out_valid !== 1'b1) check($sformatf("stream_gap_%0d", i), 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_fires", 64'(fires), 64'd100);
        check("stream_xfer_cnt", 64'(xfer_cnt), 64'd100);
        check("stream_cnt4", 64'(cnt4), 64'd4);
        check("stream_empty", 64'(bus.out_valid), 64'd0);

        // 4-bit counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) push(32'(i), 2'b00, 3'd0);
        bus.in_valid = 1'b0;
        tick();
        check("wrap_cnt4", 64'(cnt4), 64'd1);
        check("wrap_xfer_cnt", 64'(xfer_cnt), 64'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lane_swap_pipe.md
LANE_SWAP_PIPE -- requirements
Module: lane_swap_pipe

Interface
REQ-001 Parameter: DATA_W, default 32, data word width in bits.
REQ-002 Parameter: LANE_W, default 4, lane width in bits; DATA_W SHALL be a multiple of 2*LANE_W; NL = DATA_W/LANE_W.
REQ-003 Parameter: CNT_W, default 16, width of the transfer counter.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  reset, asynchronous, active-high.
REQ-006 Port: in_valid  input  1  upstream word present.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: in_data  input  DATA_W  input word.
REQ-009 Port: mode  input  2  transform select, sampled with the word: 00 pass, 01 pair-swap, 10 lane-reverse, 11 rotate.
REQ-010 Port: rot_amt  input  clog2(NL)  lane rotate amount, sampled with the word; used only in mode 11.
REQ-011 Port: out_valid  output  1  output word present.
REQ-012 Port: out_ready  input  1  downstream accepts the output word.
REQ-013 Port: out_data  output  DATA_W  transformed word.
REQ-014 Port: xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 Lane i = in_data[i*LANE_W +: LANE_W], where i = 0 is the least significant lane.
REQ-016 Mode 00 SHALL output in_data unchanged.
REQ-017 Mode 01 SHALL exchange lanes 2k and 2k+1 for every k; LANE_W=4, DATA_W=8 reproduces the classic nibble swap.
REQ-018 Mode 10 SHALL map lane i to lane NL-1-i.
REQ-019 Mode 11 SHALL rotate the word left by rot_amt*LANE_W bits; rot_amt=0 passes the word unchanged.
REQ-020 The transform SHALL be computed combinationally at acceptance; only transformed data is stored.
REQ-021 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-022 Storage: output register OR (drives out_valid/out_data) plus one skid register SK; the block holds at most 2 words.
REQ-023 in_ready SHALL equal !SK.valid, a registered value with no combinational path from out_ready.
REQ-024 On accept with OR empty or OR draining this cycle: the new word SHALL load into OR, giving 1-cycle latency.
REQ-025 On accept with OR full and out_ready=0: the new word SHALL load into SK.
REQ-026 With SK valid and out_ready=1: SK SHALL move to OR and SK SHALL clear; no input is accepted that cycle.
REQ-027 With OR full and out_ready=0: out_data SHALL hold stable.
REQ-028 Words SHALL exit in acceptance order; none dropped or duplicated.
REQ-029 out_valid SHALL deassert after the final word drains with no new accept.
REQ-030 in_valid/in_data/mode/rot_amt are ignored while in_ready=0.
REQ-031 xfer_cnt SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-032 Mode or rot_amt changes between words SHALL affect only subsequently accepted words.
REQ-033 Full throughput: with in_valid=1 and out_ready=1 continuously, one word per cycle.

Reset
REQ-034 Reset SHALL clear OR.valid and SK.valid, drive out_data=0 and xfer_cnt=0, and set in_ready=1 the cycle after release.
REQ-035 Reset asserted mid-stream SHALL discard all buffered words immediately, regardless of clk.

Verification (DATA_W=32, LANE_W=4)
REQ-036 Transform check: in 0x12345678 with mode 00/01/10 and mode 11 rot_amt=1 -> out 0x12345678 / 0x21436587 / 0x87654321 / 0x23456781, each 1 cycle after accept.
REQ-037 Backpressure: out_ready=0, push 0xA, 0xB -> in_ready falls after the 2nd accept; out_data holds 0xA; then out_ready=1 -> 0xA, 0xB out in order, in_ready=1 again.
REQ-038 Streaming: 100 words with in_valid=out_ready=1 -> 100 consecutive output cycles, xfer_cnt=100.
REQ-039 Random stalls: random in_valid/out_ready with a scoreboard -> order preserved, no loss or duplication.
REQ-040 Reset mid-op: SK and OR full, assert reset -> out_valid=0 and xfer_cnt=0 at once; after release in_ready=1 and the next word passes.
REQ-041 Wrap: CNT_W=4, 17 transfers -> xfer_cnt=1.
